// File: rtl/oled_seq_pkg.sv
// oled_seq_pkg: shared types and geometry for the OLED page sequencer
package oled_seq_pkg;

    typedef enum logic [2:0] {IDLE, SNAP, REQ, RELEASE, HOLDOFF} seq_state_t;

    localparam int PAGE_W = 128;
    localparam int COLS   = 16;
    localparam int PAGES  = 4;
    localparam int CELLS  = PAGES * COLS;

    localparam logic [7:0] CHAR_SPACE = 8'h20;

    // Write address: [5:4] selects the page, [3:0] the column
    localparam int ADDR_W   = 6;
    localparam int COL_W    = 4;
    localparam int PAGE_SEL_W = 2;
    localparam int COL_LSB  = 0;
    localparam int PAGE_LSB = COL_W;

endpackage

// File: rtl/oled_char_buffer.sv
// oled_char_buffer: 64 x 8 working text buffer with clear and flattened page read-out
module oled_char_buffer
    import oled_seq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [7:0]               wr_data,
    input  logic                     clr,
    output logic [PAGES*PAGE_W-1:0]  rd
);

    logic [7:0] mem [CELLS];

    // Character storage: clear beats a same-cycle write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CELLS; i++) mem[i] <= CHAR_SPACE;
        end else if (clr) begin
            for (int i = 0; i < CELLS; i++) mem[i] <= CHAR_SPACE;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Page p occupies rd[p*PAGE_W +: PAGE_W]; column 0 sits in the top byte
    for (genvar p = 0; p < PAGES; p++) begin : g_page
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign rd[p*PAGE_W + PAGE_W-1-8*c -: 8] = mem[p*COLS + c];
        end
    end

endmodule

// File: rtl/oled_page_sequencer.sv
// oled_page_sequencer: snapshots the text buffer onto page buses and runs the EN/FIN refresh handshake (optional OLED_SEQ_AUTO_REFRESH_EN)
module oled_page_sequencer
    import oled_seq_pkg::*;
#(
    parameter int MIN_REFRESH_CYCLES = 1000000,
    parameter int FIN_TIMEOUT        = 4000000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               WR_EN,
    input  logic [ADDR_W-1:0]  WR_ADDR,
    input  logic [7:0]         WR_DATA,
    input  logic               CLR,
    input  logic               COMMIT,
    output logic               OLED_EN,
    input  logic               OLED_FIN,
    output logic [PAGE_W-1:0]  PAGE0,
    output logic [PAGE_W-1:0]  PAGE1,
    output logic [PAGE_W-1:0]  PAGE2,
    output logic [PAGE_W-1:0]  PAGE3,
    output logic               BUSY,
    output logic               ERR
);

    localparam int TW = FIN_TIMEOUT > 1 ? $clog2(FIN_TIMEOUT) : 1;
    localparam int HW = MIN_REFRESH_CYCLES > 1 ? $clog2(MIN_REFRESH_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(FIN_TIMEOUT - 1);
    localparam logic [HW-1:0] H_LAST = HW'(MIN_REFRESH_CYCLES - 1);

    seq_state_t                state;
    logic                      pending;
    logic                      start;
    logic [TW-1:0]             tcnt;
    logic [HW-1:0]             hcnt;
    logic [PAGES*PAGE_W-1:0]   work;

    oled_char_buffer u_buf (
        .clk     (CLK),
        .rst_n   (RST),
        .wr_en   (WR_EN),
        .wr_addr (WR_ADDR),
        .wr_data (WR_DATA),
        .clr     (CLR),
        .rd      (work)
    );

`ifdef OLED_SEQ_AUTO_REFRESH_EN
    logic dirty;

    // Any edit marks the buffer dirty; an edit landing in SNAP stays pending for the next refresh
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) dirty <= 1'b0;
        else dirty <= (WR_EN || CLR) ? 1'b1 : (state == SNAP ? 1'b0 : dirty);
    end

    assign start = COMMIT || pending || dirty;
`else
    assign start = COMMIT || pending;
`endif

    assign BUSY = state != IDLE;

    // Refresh FSM: snapshot, hold EN until FIN or timeout, wait for FIN low, then rate-limit
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            OLED_EN <= 1'b0;
            ERR     <= 1'b0;
            pending <= 1'b0;
            tcnt    <= '0;
            hcnt    <= '0;
            PAGE0   <= '0;
            PAGE1   <= '0;
            PAGE2   <= '0;
            PAGE3   <= '0;
        end else begin
            ERR <= 1'b0;
            if (state != IDLE && COMMIT) pending <= 1'b1;
            case (state)
                IDLE: begin
                    pending <= 1'b0;
                    if (start) state <= SNAP;
                end
                SNAP: begin
                    PAGE0   <= work[0*PAGE_W +: PAGE_W];
                    PAGE1   <= work[1*PAGE_W +: PAGE_W];
                    PAGE2   <= work[2*PAGE_W +: PAGE_W];
                    PAGE3   <= work[3*PAGE_W +: PAGE_W];
                    OLED_EN <= 1'b1;
                    tcnt    <= '0;
                    state   <= REQ;
                end
                REQ: begin
                    if (OLED_FIN) begin
                        OLED_EN <= 1'b0;
                        state   <= RELEASE;
                    end else if (tcnt == T_LAST) begin
                        OLED_EN <= 1'b0;
                        ERR     <= 1'b1;
                        state   <= RELEASE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!OLED_FIN) begin
                        hcnt  <= '0;
                        state <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (hcnt == H_LAST) state <= IDLE;
                    else hcnt <= hcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_page_sequencer.sv
// tb_oled_page_sequencer: randomized and directed checks against a buffer/snapshot reference model
module tb_oled_page_sequencer;

    localparam int MINR = 16;
    localparam int FTO  = 64;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         WR_EN = 1'b0;
    logic [5:0]   WR_ADDR = '0;
    logic [7:0]   WR_DATA = '0;
    logic         CLR = 1'b0;
    logic         COMMIT = 1'b0;
    logic         OLED_FIN = 1'b0;
    logic         OLED_EN;
    logic [127:0] PAGE0, PAGE1, PAGE2, PAGE3;
    logic         BUSY;
    logic         ERR;

    int n_chk = 0;
    int n_pass = 0;
    int en_rises = 0;
    int err_cnt = 0;
    int fcnt = 0;
    bit fin_mute = 1'b0;
    bit en_prev = 1'b0;

    logic [7:0]   mbuf [64];
    logic [127:0] snap [4];

    oled_page_sequencer #(.MIN_REFRESH_CYCLES(MINR), .FIN_TIMEOUT(FTO)) dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .CLR(CLR), .COMMIT(COMMIT), .OLED_EN(OLED_EN), .OLED_FIN(OLED_FIN),
        .PAGE0(PAGE0), .PAGE1(PAGE1), .PAGE2(PAGE2), .PAGE3(PAGE3),
        .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [127:0] model_page(input int p);
        logic [127:0] r;
        for (int c = 0; c < 16; c++) r[127-8*c -: 8] = mbuf[p*16 + c];
        return r;
    endfunction

    function automatic logic [127:0] page_out(input int p);
        return p == 0 ? PAGE0 : p == 1 ? PAGE1 : p == 2 ? PAGE2 : PAGE3;
    endfunction

    // Controller stand-in: FIN five cycles into EN, dropped one cycle after EN falls
    always @(negedge CLK) begin
        if (!OLED_EN) begin
            fcnt = 0;
            OLED_FIN = 1'b0;
        end else if (!fin_mute) begin
            fcnt++;
            if (fcnt >= 5) OLED_FIN = 1'b1;
        end
    end

    // Reference: buffer as seen before each edge is what a fresh snapshot must show
    always @(posedge CLK) begin
        logic s_wr, s_clr;
        logic [5:0] s_addr;
        logic [7:0] s_data;
        s_wr = WR_EN; s_clr = CLR; s_addr = WR_ADDR; s_data = WR_DATA;
        #1;
        if (!RST) begin
            for (int i = 0; i < 64; i++) mbuf[i] = 8'h20;
            en_prev = 1'b0;
        end else begin
            if (OLED_EN && !en_prev) begin
                en_rises++;
                for (int p = 0; p < 4; p++) begin
                    snap[p] = model_page(p);
                    check($sformatf("snap_p%0d", p), page_out(p), snap[p]);
                end
            end
            if (!OLED_EN && en_prev)
                for (int p = 0; p < 4; p++) check($sformatf("hold_p%0d", p), page_out(p), snap[p]);
            if (ERR) err_cnt++;
            if (s_clr) for (int i = 0; i < 64; i++) mbuf[i] = 8'h20;
            else if (s_wr) mbuf[s_addr] = s_data;
            en_prev = OLED_EN;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge CLK);
        WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
        @(negedge CLK);
        WR_EN = 1'b0;
    endtask

    task automatic commit();
        @(negedge CLK);
        COMMIT = 1'b1;
        @(negedge CLK);
        COMMIT = 1'b0;
    endtask

    task automatic wait_rise(input string tag);
        int r0 = en_rises;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (en_rises > r0) break;
        end
        check(tag, 128'(en_rises > r0), 128'd1);
    endtask

    task automatic wait_fall(input string tag);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!OLED_EN) break;
        end
        check(tag, 128'(OLED_EN), 128'd0);
    endtask

    task automatic wait_quiet(input string tag);
        int q = 0;
        for (int i = 0; i < 2000 && q < 3; i++) begin
            tick();
            q = BUSY ? 0 : q + 1;
        end
        check(tag, 128'(BUSY), 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] sp, e0;
        logic [7:0] old;
        int r0, e0c;
        bit prev_en;
        sp = {16{8'h20}};
        e0 = {8'h48, 8'h49, {14{8'h20}}};

        repeat (3) @(posedge CLK);
        #2;
        check("rst_en", 128'(OLED_EN), 128'd0);
        check("rst_busy", 128'(BUSY), 128'd0);
        check("rst_err", 128'(ERR), 128'd0);
        for (int p = 0; p < 4; p++) check($sformatf("rst_p%0d", p), page_out(p), 128'd0);
        @(negedge CLK);
        RST = 1'b1;

        wr(6'h00, 8'h48);
        wr(6'h01, 8'h49);
        @(negedge CLK);
        COMMIT = 1'b1;
        tick();
        COMMIT = 1'b0;
        check("lat_en0", 128'(OLED_EN), 128'd0);
        tick();
        check("lat_en1", 128'(OLED_EN), 128'd1);
        check("hi_p0", PAGE0, e0);
        check("hi_p1", PAGE1, sp);
        check("hi_p2", PAGE2, sp);
        check("hi_p3", PAGE3, sp);
        prev_en = OLED_EN;
        for (int i = 0; i < 20; i++) begin
            if (OLED_FIN) break;
            prev_en = OLED_EN;
            tick();
        end
        check("fin_seen", 128'(OLED_FIN), 128'd1);
        check("en_before_fin", 128'(prev_en), 128'd1);
        check("en_after_fin", 128'(OLED_EN), 128'd0);
        repeat (16) tick();
        check("holdoff_busy", 128'(BUSY), 128'd1);
        tick();
        check("holdoff_done", 128'(BUSY), 128'd0);

        r0 = en_rises;
        commit();
        wait_rise("multi_rise");
        commit();
        wait_fall("multi_fall");
        repeat (3) tick();
        commit();
        tick();
        commit();
        wait_quiet("multi_quiet");
        check("multi_count", 128'(en_rises - r0), 128'd2);

        for (int it = 0; it < 6; it++) begin
            int nw = $urandom_range(1, 8);
            for (int k = 0; k < nw; k++) begin
                if ($urandom_range(0, 9) == 0) begin
                    @(negedge CLK);
                    CLR = 1'b1;
                    @(negedge CLK);
                    CLR = 1'b0;
                end else begin
                    wr(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
                end
            end
            commit();
            wait_rise($sformatf("rnd_rise%0d", it));
            wr(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
            wait_quiet($sformatf("rnd_quiet%0d", it));
        end

        old = mbuf[63];
        commit();
        wait_rise("late_rise");
        wr(6'h3F, 8'h41);
        check("late_hold", 128'(PAGE3[7:0]), 128'(old));
        wait_quiet("late_quiet");
        check("late_idle", 128'(PAGE3[7:0]), 128'(old));
        commit();
        wait_rise("late_rise2");
        check("late_new", 128'(PAGE3[7:0]), 128'h41);
        wait_quiet("late_quiet2");

        fin_mute = 1'b1;
        e0c = err_cnt;
        commit();
        wait_rise("to_rise");
        repeat (63) tick();
        check("to_err_early", 128'(ERR), 128'd0);
        check("to_en_held", 128'(OLED_EN), 128'd1);
        tick();
        check("to_err", 128'(ERR), 128'd1);
        check("to_en_drop", 128'(OLED_EN), 128'd0);
        tick();
        check("to_err_pulse", 128'(ERR), 128'd0);
        wait_quiet("to_quiet");
        check("to_err_count", 128'(err_cnt - e0c), 128'd1);
        fin_mute = 1'b0;

        @(negedge CLK);
        CLR = 1'b1; WR_EN = 1'b1; WR_ADDR = 6'h10; WR_DATA = 8'h5A;
        @(negedge CLK);
        CLR = 1'b0; WR_EN = 1'b0;
        commit();
        wait_rise("clr_rise");
        check("clr_p0", PAGE0, sp);
        check("clr_p1", PAGE1, sp);
        wait_quiet("clr_quiet");

        wr(6'h05, 8'h77);
        commit();
        wait_rise("arst_rise");
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        check("arst_en", 128'(OLED_EN), 128'd0);
        check("arst_busy", 128'(BUSY), 128'd0);
        for (int p = 0; p < 4; p++) check($sformatf("arst_p%0d", p), page_out(p), 128'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;

`ifdef OLED_SEQ_AUTO_REFRESH_EN
        repeat (2) tick();
        @(negedge CLK);
        WR_EN = 1'b1; WR_ADDR = 6'h22; WR_DATA = 8'h33;
        tick();
        WR_EN = 1'b0;
        check("auto_en_n0", 128'(OLED_EN), 128'd0);
        tick();
        check("auto_en_n1", 128'(OLED_EN), 128'd0);
        tick();
        check("auto_en_n2", 128'(OLED_EN), 128'd1);
        check("auto_p2", PAGE2, {8'h20, 8'h20, 8'h33, {13{8'h20}}});
        wait_quiet("auto_quiet");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
